// File: rtl/bcd_counter_ndigit.sv
// bcd_counter_ndigit: N-digit BCD up/down counter with internal tick divider, load, clear and wrap/saturate boundary.
module bcd_counter_ndigit #(
  parameter int DIGITS  = 2,
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 10,
  parameter int WRAP    = 1
) (
  input  logic                  CLK_50M,
  input  logic                  RESET_N,
  input  logic                  EN,
  input  logic                  UP,
  input  logic                  CLR,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   LED,
  output logic                  TICK,
  output logic                  TC
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);
  logic [DW-1:0]         div_cnt;
  logic                  tick_int;
  logic                  evt;
  logic                  boundary;
  logic                  advance;
  logic [DIGITS:0]       carry;
  logic [4*DIGITS-1:0]   cnt_nxt;
  logic [4*DIGITS-1:0]   ld_val;
  assign tick_int = div_cnt == LAST;
  assign evt      = tick_int && EN && !CLR && !LOAD;
  assign carry[0] = 1'b1;
  // carry out of the top digit means every digit sat at its boundary value
  assign boundary = carry[DIGITS];
  assign advance  = evt && !(boundary && WRAP == 0);
  genvar i;
  for (i = 0; i < DIGITS; i++) begin : g_dig
    logic [3:0] d;
    logic [3:0] lv;
    logic       at_edge;
    assign d       = LED[4*i +: 4];
    assign lv      = LOAD_VAL[4*i +: 4];
    assign at_edge = UP ? d == 4'd9 : d == 4'd0;
    assign carry[i+1] = carry[i] && at_edge;
    assign cnt_nxt[4*i +: 4] = !carry[i] ? d : at_edge ? (UP ? 4'd0 : 4'd9) : UP ? d + 4'd1 : d - 4'd1;
    assign ld_val[4*i +: 4]  = lv > 4'd9 ? 4'd9 : lv;
  end
  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt <= '0;
      LED     <= '0;
      TICK    <= 1'b0;
      TC      <= 1'b0;
    end else begin
      div_cnt <= (CLR || tick_int) ? '0 : div_cnt + 1'b1;
      TICK    <= tick_int;
      TC      <= evt && boundary;
      LED     <= CLR ? '0 : LOAD ? ld_val : advance ? cnt_nxt : LED;
    end
  end
endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// tb_bcd_counter_ndigit: random and directed stimulus on three counter variants checked against an integer reference model.
module tb_bcd_counter_ndigit;
  localparam int DIV = 5;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [15:0] lv = '0;
  logic [7:0]  led_w, led_s;
  logic [15:0] led_4;
  logic        tick_w, tick_s, tick_4, tc_w, tc_s, tc_4;
  int          checks = 0;
  int          errors = 0;
  int          nd [3] = '{2, 2, 4};
  int          wr [3] = '{1, 0, 1};
  int          m_val [3];
  bit          m_tc [3];
  bit          m_tick;
  bit          t;
  int          ph;
  int          maxv;
  always #5 clk = ~clk;
  bcd_counter_ndigit #(.DIGITS(2), .CLK_HZ(50), .TICK_HZ(10), .WRAP(1)) u_w (
    .CLK_50M(clk), .RESET_N(rst_n), .EN(en), .UP(up), .CLR(clr), .LOAD(load),
    .LOAD_VAL(lv[7:0]), .LED(led_w), .TICK(tick_w), .TC(tc_w));
  bcd_counter_ndigit #(.DIGITS(2), .CLK_HZ(50), .TICK_HZ(10), .WRAP(0)) u_s (
    .CLK_50M(clk), .RESET_N(rst_n), .EN(en), .UP(up), .CLR(clr), .LOAD(load),
    .LOAD_VAL(lv[7:0]), .LED(led_s), .TICK(tick_s), .TC(tc_s));
  bcd_counter_ndigit #(.DIGITS(4), .CLK_HZ(50), .TICK_HZ(10), .WRAP(1)) u_4 (
    .CLK_50M(clk), .RESET_N(rst_n), .EN(en), .UP(up), .CLR(clr), .LOAD(load),
    .LOAD_VAL(lv), .LED(led_4), .TICK(tick_4), .TC(tc_4));
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int bcd2int(input logic [15:0] b, input int n);
    int v = 0;
    int d;
    for (int i = n - 1; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      v = v * 10 + (d > 9 ? 9 : d);
    end
    return v;
  endfunction
  function automatic logic [15:0] int2bcd(input int v, input int n);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0;
      m_tick = 1'b0;
      for (int k = 0; k < 3; k++) begin
        m_val[k] = 0;
        m_tc[k] = 1'b0;
      end
    end else begin
      t = ph == DIV - 1;
      m_tick = t;
      ph = (clr || t) ? 0 : ph + 1;
      for (int k = 0; k < 3; k++) begin
        maxv = 10 ** nd[k] - 1;
        m_tc[k] = 1'b0;
        if (clr) m_val[k] = 0;
        else if (load) m_val[k] = bcd2int(lv, nd[k]);
        else if (t && en) begin
          if (up && m_val[k] == maxv) begin
            m_tc[k] = 1'b1;
            m_val[k] = wr[k] != 0 ? 0 : maxv;
          end else if (!up && m_val[k] == 0) begin
            m_tc[k] = 1'b1;
            m_val[k] = wr[k] != 0 ? maxv : 0;
          end else m_val[k] = up ? m_val[k] + 1 : m_val[k] - 1;
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("led_w", {8'h0, led_w}, int2bcd(m_val[0], 2));
    chk("led_s", {8'h0, led_s}, int2bcd(m_val[1], 2));
    chk("led_4", led_4, int2bcd(m_val[2], 4));
    chk("tc_w", {15'h0, tc_w}, {15'h0, m_tc[0]});
    chk("tc_s", {15'h0, tc_s}, {15'h0, m_tc[1]});
    chk("tc_4", {15'h0, tc_4}, {15'h0, m_tc[2]});
    chk("tick", {13'h0, tick_w, tick_s, tick_4}, {13'h0, {3{m_tick}}});
  end
  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    load = 1'b1;
    lv = v;
    @(negedge clk);
    load = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hold", {led_4[7:0], led_w}, 16'h0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("basic50", {8'h0, led_w}, 16'h0010);
    do_load(16'h0098);
    repeat (20) @(negedge clk);
    up = 1'b0;
    do_load(16'h0010);
    repeat (12) @(negedge clk);
    do_load(16'h0000);
    repeat (16) @(negedge clk);
    en = 1'b0;
    repeat (16) @(negedge clk);
    en = 1'b1;
    up = 1'b1;
    while (ph != DIV - 1) @(negedge clk);
    load = 1'b1;
    clr = 1'b1;
    lv = 16'h0057;
    @(negedge clk);
    chk("clr_pri", {8'h0, led_w}, 16'h0000);
    load = 1'b0;
    clr = 1'b0;
    repeat (6) @(negedge clk);
    load = 1'b1;
    lv = 16'h00A3;
    @(negedge clk);
    chk("clamp", {8'h0, led_w}, 16'h0093);
    load = 1'b0;
    do_load(16'h0047);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("arst_led", {led_w, led_4[7:0]}, 16'h0);
    chk("arst_tc", {15'h0, tc_w | tc_s | tc_4}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    do_load(16'h0999);
    repeat (6) @(negedge clk);
    do_load(16'h9999);
    repeat (6) @(negedge clk);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      en = $urandom_range(0, 3) != 0;
      up = $urandom_range(0, 1) != 0;
      clr = $urandom_range(0, 49) == 0;
      load = $urandom_range(0, 29) == 0;
      lv = $urandom_range(0, 4) == 0 ? ($urandom_range(0, 1) != 0 ? 16'h9999 : 16'h0000) : 16'($urandom);
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_counter_ndigit.md
# bcd_counter_ndigit

Parametrised N-digit BCD counter with an on-chip tick generator, direction, load and wrap/saturate modes. It succeeds the fixed 2-digit, 10 Hz, up-only counter. All state is synchronous to the single board clock: there are no ripple or divided clocks, and digit carries are enables, not clocks. It drives the LED array (4 LEDs per digit) directly and exports a tick and terminal-count strobe for cascading or other consumers.

## Interface
- DIGITS, 2, number of BCD digits (1..8)
- CLK_HZ, 50000000, input clock frequency in Hz
- TICK_HZ, 10, count rate in Hz; DIV = CLK_HZ/TICK_HZ (integer, ≥2)
- WRAP, 1, 1 = wrap at boundary, 0 = saturate at boundary

Ports:
- CLK_50M  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- EN  in  1  count enable, sampled on tick cycles only
- UP  in  1  1 = count up, 0 = count down
- CLR  in  1  synchronous clear to zero, restarts tick phase
- LOAD  in  1  synchronous load of LOAD_VAL
- LOAD_VAL  in  4*DIGITS  BCD preset, digit 0 in bits [3:0]
- LED  out  4*DIGITS  current count, BCD, digit 0 in bits [3:0]
- TICK  out  1  one-cycle strobe per DIV clocks
- TC  out  1  one-cycle terminal-count strobe

## Operation
- Divider: div_cnt counts 0..DIV-1 and wraps. The internal tick is high when div_cnt == DIV-1. TICK is a registered copy of it.
- Priority per clock edge: CLR > LOAD > count > hold.
- CLR: LED←0, div_cnt←0, TC←0.
- LOAD: LED←LOAD_VAL with each digit >9 clamped to 9. div_cnt keeps running. TC←0.
- Count event: internal tick and EN and no CLR/LOAD.
  - Up: digit 0 increments. A digit at 9 goes to 0 and enables the next digit.
  - Down: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
- Boundary (MAX = all digits 9, MIN = all 0):
  - Up at MAX: WRAP=1 gives all-zero; WRAP=0 holds MAX.
  - Down at MIN: WRAP=1 gives MAX; WRAP=0 holds MIN.
  - TC pulses on every boundary event, in either mode, including repeated saturated events.
- Non-event tick (EN=0): the count holds and TC stays 0. TICK still pulses.
- UP changing between ticks takes effect at the next event. No state depends on the previous direction.
- LED digits are always valid BCD (0..9).

## Timing
- Reset (RESET_N low, asynchronous): LED=0, div_cnt=0, TICK=0, TC=0 immediately and held while low. Release is synchronous to the next rising edge.
  - Counting starts from div_cnt=0 on the first edge after release.
  - First count event occurs on edge DIV after release.
- All outputs are registered.
  - LED updates on the event edge itself.
  - TICK and TC are high for exactly one cycle, in the cycle following the event edge. TC is coincident with the LED change.
- Tick period is exactly DIV cycles, with no drift. CLR realigns the phase: the next tick is DIV edges after the CLR edge.
- Carry propagation is combinational across digits within one cycle. There is no per-digit latency.
- CLR or LOAD asserted on a tick edge suppresses that count event and its TC.
- Reset mid-count discards all state, including a pending TC.

## Test plan
- Reset/basic (DIGITS=2, CLK_HZ=50, TICK_HZ=10, so DIV=5; UP=1, EN=1): release RESET_N → LED=00 through edge 4; LED=01 after edge 5; TICK pulse every 5 cycles; LED=10 after 50 cycles.
- Wrap up: LOAD 98, then run 2 ticks → 99, then 00 with TC=1 for one cycle. With WRAP=0: stays 99, TC pulses on each further tick.
- Down/borrow: LOAD 10, UP=0 → 09, 08. LOAD 00, UP=0, WRAP=1 → 99 with TC. WRAP=0 → holds 00 with TC.
- Enable/priority: EN=0 for 3 ticks → LED constant, TICK still pulses, TC=0. Assert LOAD=0x57 and CLR together on a tick edge → LED=00, next tick 5 edges later. LOAD_VAL=0xA3 → LED=93.
- Async reset mid-operation: at LED=47, pull RESET_N low between edges → LED=00, TC=0 immediately. Release → next increment after 5 edges.
- Width: DIGITS=4, load 0999, one up tick → 1000 with no TC. Load 9999 → 0000 with TC.
